// File: rtl/four_to_two_if.sv
// Sample bundle for the span-4 -> span-2 butterfly stage: valid flag plus eight
// signed samples in each direction.
interface four_to_two_if #(
  parameter int W = 8
);
  logic                in_valid;
  logic signed [W-1:0] din  [8];
  logic                out_valid;
  logic signed [W-1:0] dout [8];

  modport master (
    output in_valid,
    output din,
    input  out_valid,
    input  dout
  );

  modport slave (
    input  in_valid,
    input  din,
    output out_valid,
    output dout
  );
endinterface

// File: rtl/four_to_two.sv
// Registered radix-2 span-2 butterfly stage (two independent groups of four).
// Define FOURTOTWO_SAT_EN to saturate results instead of wrapping modulo 2^W.
module four_to_two #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic signed [W-1:0] in1,
  input  logic signed [W-1:0] in2,
  input  logic signed [W-1:0] in3,
  input  logic signed [W-1:0] in4,
  input  logic signed [W-1:0] in5,
  input  logic signed [W-1:0] in6,
  input  logic signed [W-1:0] in7,
  input  logic signed [W-1:0] in8,
  output logic                out_valid,
  output logic signed [W-1:0] out1,
  output logic signed [W-1:0] out2,
  output logic signed [W-1:0] out3,
  output logic signed [W-1:0] out4,
  output logic signed [W-1:0] out5,
  output logic signed [W-1:0] out6,
  output logic signed [W-1:0] out7,
  output logic signed [W-1:0] out8
);

  function automatic logic [W-1:0] bfly(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic sub);
`ifdef FOURTOTWO_SAT_EN
    logic [W:0] x;
    x = sub ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
    // Top two bits disagree only when the exact result left the W-bit range.
    if (x[W] != x[W-1]) return x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return x[W-1:0];
`else
    return sub ? (a - b) : (a + b);
`endif
  endfunction

  logic [W-1:0] out_d [8];
  logic [W-1:0] out_q [8];
  logic         valid_q;

  always_comb begin
    out_d[0] = bfly(in1, in3, 1'b0);
    out_d[1] = bfly(in2, in4, 1'b0);
    out_d[2] = bfly(in1, in3, 1'b1);
    out_d[3] = bfly(in2, in4, 1'b1);
    out_d[4] = bfly(in5, in7, 1'b0);
    out_d[5] = bfly(in6, in8, 1'b0);
    out_d[6] = bfly(in5, in7, 1'b1);
    out_d[7] = bfly(in6, in8, 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) out_q[i] <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) out_q <= out_d;
    end
  end

  assign out_valid = valid_q;
  assign out1 = out_q[0];
  assign out2 = out_q[1];
  assign out3 = out_q[2];
  assign out4 = out_q[3];
  assign out5 = out_q[4];
  assign out6 = out_q[5];
  assign out7 = out_q[6];
  assign out8 = out_q[7];

endmodule

// File: tb/tb_four_to_two.sv
// Self-checking bench for four_to_two: directed cases plus randomized traffic
// compared against an integer-arithmetic reference model.
module tb_four_to_two;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [W-1:0] exp_o [8];
  logic         exp_v;

  four_to_two_if #(.W(W)) bus ();

  four_to_two #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in1       (bus.din[0]),
    .in2       (bus.din[1]),
    .in3       (bus.din[2]),
    .in4       (bus.din[3]),
    .in5       (bus.din[4]),
    .in6       (bus.din[5]),
    .in7       (bus.din[6]),
    .in8       (bus.din[7]),
    .out_valid (bus.out_valid),
    .out1      (bus.dout[0]),
    .out2      (bus.dout[1]),
    .out3      (bus.dout[2]),
    .out4      (bus.dout[3]),
    .out5      (bus.dout[4]),
    .out6      (bus.dout[5]),
    .out7      (bus.dout[6]),
    .out8      (bus.dout[7])
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_op(input int a, input int b, input bit sub);
    int e;
    e = sub ? a - b : a + b;
`ifdef FOURTOTWO_SAT_EN
    if (e > 127) e = 127;
    if (e < -128) e = -128;
`endif
    return e[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_in(input bit v, input int d0, input int d1, input int d2, input int d3,
                        input int d4, input int d5, input int d6, input int d7);
    int d [8];
    d = '{d0, d1, d2, d3, d4, d5, d6, d7};
    bus.in_valid = v;
    for (int i = 0; i < 8; i++) bus.din[i] = d[i][W-1:0];
  endtask

  task automatic set_rand(input bit v);
    bus.in_valid = v;
    for (int i = 0; i < 8; i++) bus.din[i] = W'($urandom);
  endtask

  // Advance one edge, update the model from the sampled inputs, then compare.
  task automatic tick(input string tag);
    int a [8];
    @(posedge clk);
    for (int i = 0; i < 8; i++) a[i] = int'(bus.din[i]);
    if (rst) begin
      exp_v = 1'b0;
      for (int i = 0; i < 8; i++) exp_o[i] = '0;
    end else begin
      exp_v = bus.in_valid;
      if (bus.in_valid) begin
        for (int g = 0; g < 8; g += 4) begin
          exp_o[g]   = ref_op(a[g],   a[g+2], 1'b0);
          exp_o[g+1] = ref_op(a[g+1], a[g+3], 1'b0);
          exp_o[g+2] = ref_op(a[g],   a[g+2], 1'b1);
          exp_o[g+3] = ref_op(a[g+1], a[g+3], 1'b1);
        end
      end
    end
    #1;
    chk($sformatf("%s.valid", tag), {7'b0, bus.out_valid}, {7'b0, exp_v});
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s.out%0d", tag, i + 1), bus.dout[i], exp_o[i]);
  endtask

  initial begin
    logic [W-1:0] held [8];
    logic [W-1:0] nom  [8];
    nom = '{8'h04, 8'h06, 8'hFE, 8'hFE, 8'h0C, 8'h0E, 8'hFE, 8'hFE};
    for (int i = 0; i < 8; i++) exp_o[i] = '0;
    exp_v = 1'b0;

    // Reset held for two edges while valid inputs are presented.
    rst = 1'b1;
    set_rand(1'b1);
    tick("reset0");
    set_rand(1'b1);
    tick("reset1");
    rst = 1'b0;

    // Nominal 1..8.
    set_in(1'b1, 1, 2, 3, 4, 5, 6, 7, 8);
    tick("nominal");
    for (int i = 0; i < 8; i++) chk($sformatf("nominal_const.out%0d", i + 1), bus.dout[i], nom[i]);

    // Hold: valid low, inputs change, outputs must not move.
    for (int i = 0; i < 8; i++) held[i] = bus.dout[i];
    set_rand(1'b0);
    tick("hold");
    for (int i = 0; i < 8; i++) chk($sformatf("hold_const.out%0d", i + 1), bus.dout[i], nom[i]);

    // Overflow on the sum.
    set_in(1'b1, 127, 0, 1, 0, 0, 0, 0, 0);
    tick("overflow");
`ifdef FOURTOTWO_SAT_EN
    chk("overflow_const.out1", bus.dout[0], 8'h7F);
`else
    chk("overflow_const.out1", bus.dout[0], 8'h80);
`endif

    // Underflow on the difference.
    set_in(1'b1, 0, -128, 0, 1, 0, 0, 0, 0);
    tick("underflow");
`ifdef FOURTOTWO_SAT_EN
    chk("underflow_const.out4", bus.dout[3], 8'h80);
`else
    chk("underflow_const.out4", bus.dout[3], 8'h7F);
`endif

    // Streaming with reset on the second edge.
    set_rand(1'b1);
    tick("stream1");
    set_rand(1'b1);
    rst = 1'b1;
    tick("stream2_rst");
    chk("stream2_const.valid", {7'b0, bus.out_valid}, 8'h00);
    chk("stream2_const.out1", bus.dout[0], 8'h00);
    rst = 1'b0;
    set_rand(1'b1);
    tick("stream3");

    // Randomized traffic with occasional resets and valid gaps.
    for (int n = 0; n < 60; n++) begin
      rst = ($urandom_range(0, 15) == 0);
      set_rand(1'($urandom_range(0, 3) != 0));
      tick($sformatf("rand%0d", n));
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/four_to_two.md
Name: four_to_two

Overview:
- One registered radix-2 butterfly stage of the 8-point pipelined FFT. It sits between the span-4 stage and the span-2 stage, hence "four to two".
- Eight signed 8-bit real samples enter as two independent groups of four. Each group gets span-2 sum/difference butterflies. Results are written in-place to a one-cycle output register.
- The twiddle factor is trivial (unity) for this stage's real datapath.

Parameters:
- W, 8, sample width in bits, two's complement; all inputs and outputs use W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input samples valid this cycle
- in1..in8  in  W each  input samples, signed; in1..in4 = group A, in5..in8 = group B
- out_valid  out  1  outputs hold a valid result
- out1..out8  out  W each  output samples, signed, in-place order

Behaviour:
- Reset: on a rising clk edge with rst=1, out1..out8 <= 0 and out_valid <= 0. Reset has priority over in_valid.
- Group A butterflies (span 2):
  - out1 = in1+in3, out3 = in1-in3
  - out2 = in2+in4, out4 = in2-in4
- Group B butterflies, identical form:
  - out5 = in5+in7, out7 = in5-in7
  - out6 = in6+in8, out8 = in6-in8
- Arithmetic: W-bit two's complement. The default result wraps modulo 2^W, i.e. the low W bits of the exact sum or difference. No scaling and no rounding.
- Latency: exactly 1 clk.
  - Inputs sampled at edge N with in_valid=1 appear on out1..out8 after edge N, with out_valid=1.
  - The output register holds until the next valid capture.
- in_valid=0 at an edge:
  - out_valid <= 0.
  - out1..out8 keep their previous values (hold, no update).
- Throughput: one full 8-sample set per cycle. Back-to-back valid cycles are fully supported with no stall and no backpressure.
- Reset mid-stream: a pending result is discarded. The first valid capture after rst deasserts behaves normally.
- The two groups are fully independent: no carry or interaction between the A and B halves.
- No internal state other than the output register and out_valid.

Optional Feature:
- Macro: FOURTOTWO_SAT_EN.
- Defined: each sum/difference is computed at W+1 bits, then saturated to the W-bit range [-2^(W-1), 2^(W-1)-1]. For W=8 that is [-128, 127].
- Not defined: results wrap modulo 2^W as described above.
- Latency and handshake are identical in both builds.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 and arbitrary inputs -> out1..out8=0, out_valid=0.
- Nominal: in1..in8 = 1,2,3,4,5,6,7,8 with in_valid=1 for one edge. Required after that edge, with out_valid=1:
  - out1..out4 = 00000100, 00000110, 11111110, 11111110 (4, 6, -2, -2)
  - out5..out8 = 00001100, 00001110, 11111110, 11111110 (12, 14, -2, -2)
- Hold: drop in_valid after the nominal case and change the inputs -> out_valid=0 and outputs unchanged.
- Overflow: in1=127, in3=1 (others 0). Required out1:
  - without FOURTOTWO_SAT_EN: -128 (0x80)
  - with FOURTOTWO_SAT_EN: 127 (0x7F)
- Underflow on the difference: in2=-128, in4=1 -> out4=127 in the wrap build, -128 in the saturating build.
- Streaming with reset: 3 consecutive valid sets, each output 1 cycle after its input; assert rst on the 2nd edge -> the 2nd result is discarded (outputs 0, out_valid=0) and the 3rd result appears normally.
